pbit_sweep_ctrl: RTL and testbench
==================================

# pbit_sweep_ctrl

Sequencing controller for a p-bit array. It streams the J/h weight image into the weight memory and raises `weight_load_DONE` when the image is complete. It then runs a requested number of graph-colored sweeps by pulsing one gate-enable (`GE`) line per color, leaving a quiet gap between colors. The block sits between the host/loader interface and the p-bit array; each p-bit double-flops `GE` and `weight_load_DONE` internally.

## Interface
Parameters:
- `NUM_COLORS`, 2: number of independent color groups; width of `GE`.
- `NUM_WEIGHTS`, 64: words per weight image.
- `DATA_W`, 32: weight word width.
- `ADDR_W`, `$clog2(NUM_WEIGHTS)`: weight memory address width.
- `HOLD`, 4: cycles each color's `GE` stays high (≥1).
- `GAP`, 2: all-low cycles after each color (≥1). Covers the p-bit 2-flop sync plus neighbour settle.
- `SWEEP_W`, 16: sweep counter width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `load_start` in 1: pulse; begin a new weight image load.
- `wl_valid` in 1: weight word valid.
- `wl_data` in DATA_W: weight word.
- `wl_ready` out 1: controller accepts a word.
- `wr_en` out 1: weight memory write strobe.
- `wr_addr` out ADDR_W: write address.
- `wr_data` out DATA_W: write data.
- `weight_load_DONE` out 1: image complete and valid (level).
- `start` in 1: pulse; begin a run.
- `num_sweeps` in SWEEP_W: sweeps to run, sampled with `start`.
- `abort` in 1: terminate any activity.
- `GE` out NUM_COLORS: per-color gate enable; at most one bit is high at a time.
- `busy` out 1: LOAD or RUN in progress.
- `done` out 1: one-cycle pulse at run completion.
- `sweep_cnt` out SWEEP_W: completed sweeps in the current/last run.

## Operation
- FSM states: IDLE, LOAD, RUN_HOLD, RUN_GAP. All outputs are registered.
- Reset values: IDLE; `GE`=0, `wl_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `weight_load_DONE`=0, `busy`=0, `done`=0, `sweep_cnt`=0.
- IDLE + `load_start` causes the following, then the FSM goes to LOAD:
  - `weight_load_DONE` is cleared.
  - The word index is set to 0.
  - `busy` and `wl_ready` are set to 1.
- LOAD:
  - Each cycle with `wl_valid`&&`wl_ready` registers `wr_en`=1, `wr_addr`=index, `wr_data`=`wl_data`, and increments the index.
  - `wr_en` is 0 on cycles without a transfer.
  - On the NUM_WEIGHTS-th transfer, `wl_ready` drops at that same edge and the FSM returns to IDLE.
  - `weight_load_DONE`=1 and `busy`=0 are set on the following edge, after the last `wr_en`. `weight_load_DONE` then stays high until the next `load_start`, abort-in-LOAD, or reset.
- IDLE + `start` + `weight_load_DONE`=1:
  - If `num_sweeps`=0, `done` pulses on the next edge and the FSM stays in IDLE.
  - Otherwise `sweep_cnt` is cleared, the color is set to 0, `GE[0]`=1, `busy`=1, and the FSM goes to RUN_HOLD.
- `start` with `weight_load_DONE`=0 is ignored.
- RUN_HOLD: `GE[color]` is held for HOLD cycles, then all `GE`=0 and the FSM goes to RUN_GAP.
- RUN_GAP: after GAP cycles:
  - If color < NUM_COLORS-1: color+1, raise that `GE` bit, go to RUN_HOLD.
  - Otherwise `sweep_cnt`+1. If it equals the latched `num_sweeps`: `busy`=0, `done`=1 for one cycle, go to IDLE. Else color 0, go to RUN_HOLD.
- `start`/`load_start` while `busy` are ignored. `num_sweeps` is latched at start; later changes have no effect.
- `load_start` and `start` in the same IDLE cycle: `load_start` wins.
- `abort` has highest priority in any state. The next edge forces `GE`=0, `wr_en`=0, `wl_ready`=0, `busy`=0, and IDLE; no `done` pulse.
  - Abort in LOAD also leaves `weight_load_DONE`=0.
  - Abort in RUN keeps `weight_load_DONE`=1 and freezes `sweep_cnt`.
- Async reset mid-LOAD or mid-RUN returns immediately to the reset values.

## Timing
- Let edge n be the edge where `start` is sampled in IDLE.
- `GE[0]` is high from edge n to edge n+HOLD.
- Color c rises at edge n + c·(HOLD+GAP) within a sweep. A sweep lasts NUM_COLORS·(HOLD+GAP) cycles.
- `done` is high for the cycle after edge n + S·NUM_COLORS·(HOLD+GAP), where S = `num_sweeps`. `busy` falls on that same edge.
- There are never two `GE` bits high at once, and there is always at least GAP all-zero cycles between consecutive `GE` bits.
- Load throughput is one word per cycle with `wl_valid` held high. `weight_load_DONE` rises exactly one edge after the final `wr_en` edge.

## Test plan
- Reset, then `load_start`, then 64 words with `wl_valid` held high (data = address) -> 64 consecutive `wr_en` pulses with addresses 0..63; `wl_ready` low after word 64; `weight_load_DONE`=1 one edge later.
- Load with `wl_valid` toggling 1/0 -> exactly 64 writes, no address skipped or repeated; `wr_en`=0 on idle cycles.
- `start` with `num_sweeps`=3, defaults (HOLD=4, GAP=2, 2 colors) -> `GE` pattern 01×4, 00×2, 10×4, 00×2, repeated 3×; `done` exactly 36 cycles after start; `sweep_cnt`=3.
- `start` before any load -> ignored, `GE`=0. `start` with `num_sweeps`=0 after a load -> single `done` pulse with no `GE` activity.
- `abort` at cycle 7 of a run -> `GE`=0 next edge, no `done`, `sweep_cnt`=0, `weight_load_DONE` still 1. `abort` mid-load -> `weight_load_DONE`=0.
- `rst_n` low mid-run (asynchronously, between edges) -> all outputs at reset values immediately. `load_start`+`start` in the same cycle -> LOAD entered, run not started.

Source files
------------

// File: rtl/pbit_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pbit_sweep_ctrl
//  Description : Sequencing controller for a p-bit array. Streams the J/h
//                weight image into weight memory, then runs graph-colored
//                sweeps by pulsing one gate-enable line per color with a
//                quiet gap between colors.
//  Revision    : 1.0 - initial release
// ============================================================================
module pbit_sweep_ctrl #(
    parameter int NUM_COLORS  = 2,
    parameter int NUM_WEIGHTS = 64,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = $clog2(NUM_WEIGHTS),
    parameter int HOLD        = 4,
    parameter int GAP         = 2,
    parameter int SWEEP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // weight loader
    input  logic                  load_start,
    input  logic                  wl_valid,
    input  logic [DATA_W-1:0]     wl_data,
    output logic                  wl_ready,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  weight_load_DONE,
    // sweep control
    input  logic                  start,
    input  logic [SWEEP_W-1:0]    num_sweeps,
    input  logic                  abort,
    output logic [NUM_COLORS-1:0] GE,
    output logic                  busy,
    output logic                  done,
    output logic [SWEEP_W-1:0]    sweep_cnt
);

    // Phase counter must reach the larger of HOLD-1 and GAP-1.
    localparam int c_PH_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;
    localparam int c_COL_W  = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;

    localparam logic [c_PH_W-1:0]     c_HOLD_LAST  = c_PH_W'(HOLD - 1);
    localparam logic [c_PH_W-1:0]     c_GAP_LAST   = c_PH_W'(GAP - 1);
    localparam logic [c_COL_W-1:0]    c_COLOR_LAST = c_COL_W'(NUM_COLORS - 1);
    localparam logic [ADDR_W-1:0]     c_IDX_LAST   = ADDR_W'(NUM_WEIGHTS - 1);
    localparam logic [NUM_COLORS-1:0] c_GE_ONE     = NUM_COLORS'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_RUN_HOLD = 2'd2,
        S_RUN_GAP  = 2'd3
    } state_t;

    // registered state
    state_t                r_state;
    logic [ADDR_W-1:0]     r_idx;
    logic [c_PH_W-1:0]     r_ph_cnt;
    logic [c_COL_W-1:0]    r_color;
    logic [SWEEP_W-1:0]    r_num_sweeps;
    logic                  r_load_fin;   // last word written; publish image next edge
    logic [NUM_COLORS-1:0] r_ge;
    logic                  r_wl_ready;
    logic                  r_wr_en;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  r_wld;
    logic                  r_busy;
    logic                  r_done;
    logic [SWEEP_W-1:0]    r_sweep_cnt;

    // next-state values
    state_t                w_state;
    logic [ADDR_W-1:0]     w_idx;
    logic [c_PH_W-1:0]     w_ph_cnt;
    logic [c_COL_W-1:0]    w_color;
    logic [SWEEP_W-1:0]    w_num_sweeps;
    logic                  w_load_fin;
    logic [NUM_COLORS-1:0] w_ge;
    logic                  w_wl_ready;
    logic                  w_wr_en;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [DATA_W-1:0]     w_wr_data;
    logic                  w_wld;
    logic                  w_busy;
    logic                  w_done;
    logic [SWEEP_W-1:0]    w_sweep_cnt;

    logic [c_COL_W-1:0]    w_color_inc;
    logic [SWEEP_W-1:0]    w_sweep_inc;

    assign w_color_inc = r_color + 1'b1;
    assign w_sweep_inc = r_sweep_cnt + 1'b1;

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_ph_cnt     = r_ph_cnt;
        w_color      = r_color;
        w_num_sweeps = r_num_sweeps;
        w_load_fin   = 1'b0;
        w_ge         = r_ge;
        w_wl_ready   = r_wl_ready;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_wr_data    = r_wr_data;
        w_wld        = r_wld;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_sweep_cnt  = r_sweep_cnt;

        if (abort) begin
            // Image stays invalid if the load was cut short; a run keeps
            // its image and its frozen sweep count.
            w_state    = S_IDLE;
            w_ge       = '0;
            w_wl_ready = 1'b0;
            w_busy     = 1'b0;
            if (r_state == S_LOAD) begin
                w_wld = 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_load_fin) begin
                        // Final word was written on the previous edge.
                        w_wld  = 1'b1;
                        w_busy = 1'b0;
                    end else if (load_start) begin
                        w_wld      = 1'b0;
                        w_idx      = '0;
                        w_busy     = 1'b1;
                        w_wl_ready = 1'b1;
                        w_state    = S_LOAD;
                    end else if (start && r_wld) begin
                        if (num_sweeps == '0) begin
                            w_done = 1'b1;
                        end else begin
                            w_num_sweeps = num_sweeps;
                            w_sweep_cnt  = '0;
                            w_color      = '0;
                            w_ph_cnt     = '0;
                            w_ge         = c_GE_ONE;
                            w_busy       = 1'b1;
                            w_state      = S_RUN_HOLD;
                        end
                    end
                end

                S_LOAD: begin
                    if (wl_valid && r_wl_ready) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_idx;
                        w_wr_data = wl_data;
                        if (r_idx == c_IDX_LAST) begin
                            w_wl_ready = 1'b0;
                            w_load_fin = 1'b1;
                            w_state    = S_IDLE;
                        end else begin
                            w_idx = r_idx + 1'b1;
                        end
                    end
                end

                S_RUN_HOLD: begin
                    if (r_ph_cnt == c_HOLD_LAST) begin
                        w_ge     = '0;
                        w_ph_cnt = '0;
                        w_state  = S_RUN_GAP;
                    end else begin
                        w_ph_cnt = r_ph_cnt + 1'b1;
                    end
                end

                S_RUN_GAP: begin
                    if (r_ph_cnt == c_GAP_LAST) begin
                        w_ph_cnt = '0;
                        if (r_color != c_COLOR_LAST) begin
                            w_color = w_color_inc;
                            w_ge    = c_GE_ONE << w_color_inc;
                            w_state = S_RUN_HOLD;
                        end else begin
                            w_sweep_cnt = w_sweep_inc;
                            if (w_sweep_inc == r_num_sweeps) begin
                                w_busy  = 1'b0;
                                w_done  = 1'b1;
                                w_state = S_IDLE;
                            end else begin
                                w_color = '0;
                                w_ge    = c_GE_ONE;
                                w_state = S_RUN_HOLD;
                            end
                        end
                    end else begin
                        w_ph_cnt = r_ph_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_ph_cnt     <= '0;
            r_color      <= '0;
            r_num_sweeps <= '0;
            r_load_fin   <= 1'b0;
            r_ge         <= '0;
            r_wl_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wld        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sweep_cnt  <= '0;
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_ph_cnt     <= w_ph_cnt;
            r_color      <= w_color;
            r_num_sweeps <= w_num_sweeps;
            r_load_fin   <= w_load_fin;
            r_ge         <= w_ge;
            r_wl_ready   <= w_wl_ready;
            r_wr_en      <= w_wr_en;
            r_wr_addr    <= w_wr_addr;
            r_wr_data    <= w_wr_data;
            r_wld        <= w_wld;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_sweep_cnt  <= w_sweep_cnt;
        end
    end

    assign GE               = r_ge;
    assign wl_ready         = r_wl_ready;
    assign wr_en            = r_wr_en;
    assign wr_addr          = r_wr_addr;
    assign wr_data          = r_wr_data;
    assign weight_load_DONE = r_wld;
    assign busy             = r_busy;
    assign done             = r_done;
    assign sweep_cnt        = r_sweep_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pbit_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pbit_sweep_ctrl
//  Description : Self-checking bench for pbit_sweep_ctrl. Expected values
//                come from a timing model built on the sweep period formula.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pbit_sweep_ctrl;

    localparam int NC = 2;
    localparam int NW = 64;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int H  = 4;
    localparam int G  = 2;
    localparam int SW = 16;
    localparam int P  = NC * (H + G);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          wl_valid = 1'b0;
    logic [DW-1:0] wl_data = '0;
    logic          wl_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          weight_load_DONE;
    logic          start = 1'b0;
    logic [SW-1:0] num_sweeps = '0;
    logic          abort = 1'b0;
    logic [NC-1:0] GE;
    logic          busy;
    logic          done;
    logic [SW-1:0] sweep_cnt;

    int vectors = 0;
    int miscompares = 0;

    // model state carried between operations
    bit            m_wld = 1'b0;
    logic [SW-1:0] m_sweep = '0;

    pbit_sweep_ctrl #(
        .NUM_COLORS(NC), .NUM_WEIGHTS(NW), .DATA_W(DW), .ADDR_W(AW),
        .HOLD(H), .GAP(G), .SWEEP_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .wl_valid(wl_valid), .wl_data(wl_data),
        .wl_ready(wl_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .weight_load_DONE(weight_load_DONE),
        .start(start), .num_sweeps(num_sweeps), .abort(abort),
        .GE(GE), .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_GE"}, 64'(GE), 0);
        chk({tag, "_wl_ready"}, 64'(wl_ready), 0);
        chk({tag, "_wr_en"}, 64'(wr_en), 0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 0);
        chk({tag, "_wr_data"}, 64'(wr_data), 0);
        chk({tag, "_wld"}, 64'(weight_load_DONE), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_sweep_cnt"}, 64'(sweep_cnt), 0);
    endtask

    // mode 0: wl_valid held high, 1: toggling, 2: random
    task automatic do_load(input int mode, input bit pre_started);
        int n;
        int iter;
        logic v;
        logic [DW-1:0] d;
        if (!pre_started) begin
            @(negedge clk); load_start = 1'b1;
            @(negedge clk); load_start = 1'b0;
        end
        chk("load_ready", 64'(wl_ready), 1);
        chk("load_busy", 64'(busy), 1);
        chk("load_wld_clr", 64'(weight_load_DONE), 0);
        n = 0;
        iter = 0;
        while (n < NW && iter < 1000) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = ~iter[0];
            else                v = 1'($urandom_range(0, 1));
            d = $urandom;
            wl_valid = v;
            wl_data  = d;
            @(negedge clk);
            iter++;
            chk("wr_en", 64'(wr_en), 64'(v));
            if (v) begin
                chk("wr_addr", 64'(wr_addr), 64'(n));
                chk("wr_data", 64'(wr_data), 64'(d));
                n++;
            end
            chk("wl_ready", 64'(wl_ready), 64'(n < NW));
            if (n == NW) chk("wld_not_yet", 64'(weight_load_DONE), 0);
        end
        wl_valid = 1'b0;
        if (n < NW) chk("load_timeout", 64'(n), 64'(NW));
        @(negedge clk);
        chk("wr_en_after", 64'(wr_en), 0);
        chk("wld_set", 64'(weight_load_DONE), 1);
        chk("load_busy_fall", 64'(busy), 0);
        m_wld = 1'b1;
    endtask

    // abort_at = 0: no abort; else abort is sampled at edge n+abort_at
    task automatic do_run(input int s, input int abort_at);
        logic [SW-1:0] base;
        logic [NC-1:0] e_ge;
        logic          e_busy;
        logic          e_done;
        logic [SW-1:0] e_sweep;
        int            tend;
        base = m_sweep;
        @(negedge clk); start = 1'b1; num_sweeps = SW'(s);
        @(negedge clk); start = 1'b0;
        if (!m_wld) begin
            for (int t = 0; t < 4; t++) begin
                chk("ign_GE", 64'(GE), 0);
                chk("ign_busy", 64'(busy), 0);
                chk("ign_done", 64'(done), 0);
                @(negedge clk);
            end
            return;
        end
        tend = s * P + 3;
        e_sweep = base;
        for (int t = 0; t <= tend; t++) begin
            if (abort_at != 0 && t >= abort_at) begin
                e_ge = '0; e_busy = 1'b0; e_done = 1'b0;
                e_sweep = SW'((abort_at - 1) / P);
            end else if (s == 0) begin
                e_ge = '0; e_busy = 1'b0; e_done = (t == 0);
                e_sweep = base;
            end else begin
                e_busy = (t < s * P);
                e_done = (t == s * P);
                e_ge = '0;
                if (e_busy && (t % (H + G)) < H) e_ge = NC'(1) << ((t % P) / (H + G));
                e_sweep = SW'((t / P < s) ? t / P : s);
            end
            chk("run_GE", 64'(GE), 64'(e_ge));
            chk("run_busy", 64'(busy), 64'(e_busy));
            chk("run_done", 64'(done), 64'(e_done));
            chk("run_sweep_cnt", 64'(sweep_cnt), 64'(e_sweep));
            if (abort_at != 0 && t >= abort_at)
                chk("abort_keeps_wld", 64'(weight_load_DONE), 1);
            abort = (abort_at != 0 && t == abort_at - 1);
            if (t < s * P - 1 && (abort_at == 0 || t < abort_at - 1)) begin
                start      = ($urandom_range(0, 3) == 0);
                load_start = ($urandom_range(0, 4) == 0);
                num_sweeps = SW'($urandom);
            end else begin
                start      = 1'b0;
                load_start = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0; start = 1'b0; load_start = 1'b0;
        m_sweep = e_sweep;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // start with no image loaded is ignored
        do_run(3, 0);

        do_load(0, 1'b0);
        do_run(3, 0);
        do_load(1, 1'b0);
        do_run(0, 0);
        do_run(3, 7);
        for (int k = 0; k < 3; k++) do_run(1 + $urandom_range(0, 2), 0);
        do_run(3, 1 + $urandom_range(0, 2 * P - 2));

        // abort in the middle of a load
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0; wl_valid = 1'b1; wl_data = $urandom;
        repeat (10) @(negedge clk);
        abort = 1'b1; wl_valid = 1'b0;
        @(negedge clk); abort = 1'b0;
        chk("ldabort_wld", 64'(weight_load_DONE), 0);
        chk("ldabort_busy", 64'(busy), 0);
        chk("ldabort_ready", 64'(wl_ready), 0);
        chk("ldabort_wr_en", 64'(wr_en), 0);
        m_wld = 1'b0;
        do_run(2, 0);
        do_load(2, 1'b0);

        // load_start and start together: load wins
        @(negedge clk); load_start = 1'b1; start = 1'b1; num_sweeps = 16'd2;
        @(negedge clk); load_start = 1'b0; start = 1'b0;
        chk("both_GE", 64'(GE), 0);
        m_wld = 1'b0;
        do_load(0, 1'b1);
        do_run(2, 0);

        // asynchronous reset mid-run
        @(negedge clk); start = 1'b1; num_sweeps = 16'd2;
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk); rst_n = 1'b1;
        m_wld = 1'b0; m_sweep = '0;
        do_run(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
